// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx byte-transmitter arbiter.
// State encoding, a constant clog2 and the default busy-rise timeout.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 15;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side req/ack bundle plus the uart_tx en/data/busy link.
// master = requesters and uart_tx; slave = the arbiter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int IW = clog2(N_REQ);

  // Handshake: requester k raises req[k] with req_data[8k+7:8k] stable and holds
  // both until the single-cycle ack[k]; it may keep req high with a new byte after.
  // tx_en is a one-cycle pulse to uart_tx; tx_busy is uart_tx's registered busy.
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic               tx_en;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic [IW-1:0]      grant_id;

  modport master (
    output req, req_data, tx_busy,
    input  ack, tx_en, tx_data, grant_id
  );

  modport slave (
    input  req, req_data, tx_busy,
    output ack, tx_en, tx_data, grant_id
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req scanning ptr, ptr+1, ...
// modulo N_REQ. Kept generic for other multi-source arbiters.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW:0]        sum;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_REQ-1:0];
    valid = |rot;
    sum   = '0;
    // Descending scan so the smallest offset from ptr wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) sum = (IW+1)'(i) + {1'b0, ptr};
    end
    if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one uart_tx from N_REQ requesters, one byte at a time.
// Optional busy-rise watchdog with sticky err output: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus,
  output arb_state_t       dbg_state
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  localparam int IW = clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT 1..255");
  end

  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    grant_id_q;
  logic [7:0]       tx_data_q;
  logic             tx_en_q;
  logic [N_REQ-1:0] ack_q;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [7:0]       pick_byte;
  logic [IW-1:0]    ptr_next;
`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0]       wait_cnt;
  logic             err_q;
`endif

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_byte = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == IW'(k)) pick_byte = bus.req_data[8*k +: 8];
    end
  end

  // The last winner drops to lowest priority for the next arbitration.
  assign ptr_next = (grant_id_q == IW'(N_REQ - 1)) ? '0 : grant_id_q + IW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_id_q <= '0;
      tx_data_q  <= 8'h00;
      tx_en_q    <= 1'b0;
      ack_q      <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wait_cnt   <= 8'h00;
      err_q      <= 1'b0;
`endif
    end else begin
      tx_en_q <= 1'b0;
      ack_q   <= '0;
      case (state)
        IDLE: begin
          // Also waits out a frame left running by a mid-operation reset.
          if (pick_valid && !bus.tx_busy) begin
            tx_data_q  <= pick_byte;
            grant_id_q <= pick_idx;
            tx_en_q    <= 1'b1;
            ack_q      <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef UART_ARB_TIMEOUT_EN
          wait_cnt <= 8'h00;
`endif
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          // uart_tx registers busy, so the first cycle here normally sees it low.
          if (bus.tx_busy) begin
            state <= WAIT_LO;
`ifdef UART_ARB_TIMEOUT_EN
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            ptr   <= ptr_next;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
`endif
          end
        end
        WAIT_LO: begin
          // busy falls at the stop bit, so the next issue chains without a gap.
          if (!bus.tx_busy) begin
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant_id = grant_id_q;
  assign dbg_state    = state;
`ifdef UART_ARB_TIMEOUT_EN
  assign err          = err_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small behavioural uart_tx (4 clk/bit).
// The busy-rise watchdog case runs only when UART_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N     = 4;
  localparam int BIT   = 4;
  localparam int FRAME = 10 * BIT;
  localparam int TO    = DEFAULT_TIMEOUT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  arb_state_t dbg_state;
`ifdef UART_ARB_TIMEOUT_EN
  logic err;
`endif

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
`ifdef UART_ARB_TIMEOUT_EN
    .err       (err),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] src_q[N][$];
  int g_q[$];
  int start_q[$];
  int ack_cnt[N] = '{default: 0};
  int rx_cnt = 0;
  logic [N-1:0] pulse = '0;
  logic [N-1:0] ack_s = '0;
  logic block = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural uart_tx ----------------
  logic       m_active = 1'b0;
  logic       m_busy   = 1'b0;
  logic       m_pend   = 1'b0;
  int         m_bit    = 0;
  int         m_cnt    = 0;
  logic [7:0] m_sh     = 8'h00;
  logic [7:0] m_pdata  = 8'h00;
  logic       en_eff;
  logic       line;
  logic [7:0] rx_sh = 8'h00;

  assign en_eff      = bus.tx_en & ~block;
  assign bus.tx_busy = m_busy;

  always_comb begin
    line = 1'b1;
    if (m_active) begin
      if (m_bit == 0) line = 1'b0;
      else if (m_bit == 9) line = 1'b1;
      else line = m_sh[m_bit-1];
    end
  end

  always @(posedge clk) begin
    if (m_active) begin
      if (m_cnt == BIT - 1) begin
        m_cnt <= 0;
        if (m_bit == 9) begin
          if (m_pend || en_eff) begin
            m_bit  <= 0;
            m_sh   <= m_pend ? m_pdata : bus.tx_data;
            m_pend <= 1'b0;
            m_busy <= 1'b1;
          end else begin
            m_active <= 1'b0;
          end
        end else begin
          m_bit <= m_bit + 1;
          if (m_bit == 8) m_busy <= 1'b0;
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
      if (en_eff && !(m_cnt == BIT - 1 && m_bit == 9)) begin
        m_pend  <= 1'b1;
        m_pdata <= bus.tx_data;
      end
    end else if (en_eff) begin
      m_active <= 1'b1;
      m_bit    <= 0;
      m_cnt    <= 0;
      m_sh     <= bus.tx_data;
      m_busy   <= 1'b1;
    end
  end

  // ---------------- requester driver ----------------
  always @(negedge clk) ack_s = bus.ack;

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < N; k++) begin
        if (ack_s[k] && src_q[k].size() != 0) void'(src_q[k].pop_front());
        bus.req[k] = (src_q[k].size() != 0) | pulse[k];
        bus.req_data[8*k +: 8] = (src_q[k].size() != 0) ? src_q[k][0] : 8'h00;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) if (bus.ack[k]) ack_cnt[k]++;
    if (bus.tx_en) begin
      g_q.push_back(int'(bus.grant_id));
      check_eq("issue_busy_low", 32'(bus.tx_busy), 32'd0);
      check_eq("ack_matches_grant", 32'(bus.ack), 32'd1 << bus.grant_id);
    end else if (bus.ack != '0) begin
      check_eq("ack_without_en", 32'(bus.tx_en), 32'd1);
    end
    if (m_active && m_cnt == 0 && m_bit == 0) start_q.push_back(cyc);
    if (m_active && m_cnt == BIT / 2) begin
      if (m_bit == 0) begin
        check_eq("start_bit", 32'(line), 32'd0);
      end else if (m_bit <= 8) begin
        rx_sh[m_bit-1] = line;
      end else begin
        check_eq("stop_bit", 32'(line), 32'd1);
        check_eq("rx_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
        rx_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input int k, input logic [7:0] d, input bit sent);
    src_q[k].push_back(d);
    if (sent) exp_q.push_back(d);
  endtask

  task automatic reset_dut();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    g_q.delete();
    start_q.delete();
  endtask

  task automatic wait_ack(input int k, output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (bus.ack[k]) ok = 1'b1;
    end
    check_eq("ack_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_state(input arb_state_t st);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      if (dbg_state == st) ok = 1'b1;
    end
    check_eq("state_reached", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (dbg_state == IDLE && !m_active && !m_busy && !m_pend && bus.req == '0) ok = 1'b1;
    end
    check_eq("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic check_spacing(input int n_exp);
    check_eq("frame_count", 32'(start_q.size()), 32'(n_exp));
    for (int i = 1; i < start_q.size(); i++)
      check_eq("start_spacing", 32'(start_q[i] - start_q[i-1]), 32'(FRAME));
  endtask

  task automatic check_reset_vals();
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rst_ack", 32'(bus.ack), 32'd0);
    check_eq("rst_tx_en", 32'(bus.tx_en), 32'd0);
    check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check_eq("rst_grant_id", 32'(bus.grant_id), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int base[N];
    int a1;
    int rx0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
`ifdef UART_ARB_TIMEOUT_EN
    check_eq("rst_err", 32'(err), 32'd0);
`endif

    // Single requester 1 sends 0xA5: ack one cycle after req is sampled.
    step();
    push_byte(1, 8'hA5, 1'b1);
    wait_ack(1, lat);
    check_eq("t1_ack_latency", 32'(lat), 32'd2);
    check_eq("t1_tx_en", 32'(bus.tx_en), 32'd1);
    check_eq("t1_tx_data", 32'(bus.tx_data), 32'hA5);
    check_eq("t1_grant_id", 32'(bus.grant_id), 32'd1);
    @(negedge clk);
    check_eq("t1_tx_en_width", 32'(bus.tx_en), 32'd0);
    check_eq("t1_ack_width", 32'(bus.ack), 32'd0);
    check_eq("t1_wait_hi", 32'(dbg_state), 32'(WAIT_HI));
    wait_idle();
    check_eq("t1_rx_cnt", 32'(rx_cnt), 32'd1);

    // req 0 and 2 together: 0x11 first, 0x22 chained inside its stop bit.
    reset_dut();
    step();
    push_byte(0, 8'h11, 1'b1);
    push_byte(2, 8'h22, 1'b1);
    wait_idle();
    check_eq("t2_grants", 32'(g_q.size()), 32'd2);
    if (g_q.size() == 2) begin
      check_eq("t2_first", 32'(g_q[0]), 32'd0);
      check_eq("t2_second", 32'(g_q[1]), 32'd2);
    end
    check_spacing(2);

    // All four requesters, two bytes each: strict rotation 0,1,2,3,0,1,2,3.
    reset_dut();
    for (int k = 0; k < N; k++) base[k] = ack_cnt[k];
    step();
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < N; k++) push_byte(k, 8'(8'h40 + 16*k + j), 1'b1);
    wait_idle();
    check_eq("t3_grants", 32'(g_q.size()), 32'd8);
    for (int i = 0; i < g_q.size() && i < 8; i++)
      check_eq("t3_grant_order", 32'(g_q[i]), 32'(i % N));
    for (int k = 0; k < N; k++)
      check_eq("t3_ack_count", 32'(ack_cnt[k] - base[k]), 32'd2);
    check_spacing(8);

    // Reset in WAIT_LO: outputs clear at once; pending req 3 waits for the old frame.
    reset_dut();
    step();
    push_byte(2, 8'h5A, 1'b1);
    wait_state(WAIT_LO);
    step();
    push_byte(3, 8'hC3, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    check_eq("t4_frame_running", 32'(m_busy), 32'd1);
    wait_idle();
    check_eq("t4_grants", 32'(g_q.size()), 32'd2);
    if (g_q.size() == 2) check_eq("t4_second_grant", 32'(g_q[1]), 32'd3);

    // One-cycle req 1 pulse during WAIT_LO is not sampled.
    reset_dut();
    step();
    push_byte(0, 8'h3C, 1'b1);
    wait_state(WAIT_LO);
    a1  = ack_cnt[1];
    rx0 = rx_cnt;
    step();
    pulse[1] = 1'b1;
    step();
    pulse[1] = 1'b0;
    wait_idle();
    repeat (10) step();
    check_eq("t6_no_ack1", 32'(ack_cnt[1] - a1), 32'd0);
    check_eq("t6_one_frame", 32'(rx_cnt - rx0 + 1), 32'd2);
    check_eq("t6_grants", 32'(g_q.size()), 32'd1);

`ifdef UART_ARB_TIMEOUT_EN
    // Busy never rises: err at issue+1+TIMEOUT and the FSM drops back to IDLE.
    reset_dut();
    block = 1'b1;
    step();
    push_byte(2, 8'h77, 1'b0);
    wait_ack(2, lat);
    lat = 0;
    for (int i = 0; i < 100 && err !== 1'b1; i++) begin
      @(negedge clk);
      lat++;
    end
    check_eq("t5_err_cycle", 32'(lat), 32'(TO + 1));
    check_eq("t5_state_idle", 32'(dbg_state), 32'(IDLE));
    repeat (5) @(negedge clk);
    check_eq("t5_err_sticky", 32'(err), 32'd1);
    block = 1'b0;
    reset_dut();
    @(negedge clk);
    check_eq("t5_err_cleared", 32'(err), 32'd0);
`endif

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    check_eq("rx_total", 32'(rx_cnt), 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` byte transmitter among `N_REQ` requesters. It sits directly in front of `uart_tx` and owns that block's `en`/`data` inputs. It observes `busy` to sequence one byte at a time, and queues the next byte during the stop bit so back-to-back frames carry no idle gap. Each requester sees a simple req/ack handshake.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 15: cycles to wait for `tx_busy` to rise after an issue. Used only with `UART_ARB_TIMEOUT_EN`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in, 1: system clock, same clock as `uart_tx`.
- `rst` in, 1: synchronous active-high reset.
- `req` in, N_REQ: per-requester byte-pending flag.
- `req_data` in, 8*N_REQ: byte of requester k in bits [8k+7:8k].
- `ack` out, N_REQ: one-cycle pulse; that requester's byte has been taken.
- `tx_en` out, 1: to `uart_tx.en`.
- `tx_data` out, 8: to `uart_tx.data`.
- `tx_busy` in, 1: from `uart_tx.busy`.
- `grant_id` out, clog2(N_REQ): index of the current or last winner.
- `err` out, 1: sticky timeout flag. Present only with `UART_ARB_TIMEOUT_EN`.

## Operation
- All outputs are registered. Reset values: `ack`=0, `tx_en`=0, `tx_data`=0, `grant_id`=0, `err`=0. Reset also sets state=IDLE and the round-robin pointer `ptr`=0.
- Requester rule: raise `req` with `req_data` stable, and hold both until `ack`. After `ack`, the requester may keep `req` high with new data for its next byte. If `req` drops before it is sampled in IDLE, the request is ignored. No error is raised.
- State machine:
  - IDLE: if `|req` and `tx_busy`=0, pick the winner. The winner is the first asserted index scanning `ptr`, `ptr`+1, … modulo N_REQ. Latch the winner's byte into `tx_data`, set `grant_id`, go to ISSUE. If `tx_busy`=1, stay in IDLE.
  - ISSUE: `tx_en`=1 and `ack[grant_id]`=1, both for exactly this cycle. Go to WAIT_HI.
  - WAIT_HI: wait for `tx_busy`=1, then go to WAIT_LO. `uart_tx` registers busy one cycle after `en`, so `tx_busy`=0 on the first WAIT_HI cycle is normal.
  - WAIT_LO: wait for `tx_busy`=0, then set `ptr` = (`grant_id`+1) mod N_REQ and go to IDLE.
- `tx_busy` falls at the start of the stop bit. The next issue therefore lands inside the stop bit, and `uart_tx` chains straight into the next start bit.
- Round-robin guarantee: the last winner has lowest priority in the next arbitration. With all requesters active, the grant order is 0,1,…,N_REQ-1,0,…
- Simultaneous events: a new `req` edge during ISSUE, WAIT_HI or WAIT_LO is held until the next IDLE. A change of `req_data` after the ISSUE latch has no effect on the byte being sent.
- Reset mid-operation (any state): the FSM returns to IDLE next cycle, and no `ack` or `tx_en` pulse is emitted. A frame already running in `uart_tx` completes on its own. The arbiter waits for `tx_busy`=0 in IDLE before the next issue.

## Timing
- `req` sampled high in IDLE at cycle 0 → `tx_en` and `ack` high in cycle 1 → WAIT_HI from cycle 2.
- Minimum per-byte overhead inside the arbiter is 3 cycles plus the time `tx_busy` is high.
- Start-to-start spacing of back-to-back frames equals exactly 10 bit periods of `uart_tx`.
- `ack` is never high for more than one cycle, and never for two requesters at once.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter runs in WAIT_HI.
  - If `tx_busy` is still 0 after `TIMEOUT` cycles, set `err`=1 (sticky until `rst`) and go to IDLE.
  - The byte counts as acked-and-lost, and `ptr` advances.
- Undefined: WAIT_HI waits indefinitely. The `err` port and the counter are absent.

## Structure
- Package `uart_arb_pkg` holds:
  - the FSM state encoding (IDLE=0, ISSUE=1, WAIT_HI=2, WAIT_LO=3, 2 bits);
  - the `clog2` function;
  - the default `TIMEOUT` constant.
- Sub-module `rr_pick`: combinational rotate-by-`ptr` priority encoder. Inputs are `req` and `ptr`; outputs are `valid` and `idx`. It is reused for any later multi-source peripheral arbiter.

## Test plan
- Single requester 1 sends 0xA5 → `ack[1]` pulses 1 cycle after `req` sampled, `tx_en` for exactly 1 cycle with `tx_data`=0xA5, and the serial line carries start, 1,0,1,0,0,1,0,1, stop.
- `req[0]` and `req[2]` raised in the same cycle, data 0x11 and 0x22 → 0x11 sent first, 0x22 queued during its stop bit, with no idle bit between frames.
- All four requesters held high for 8 bytes → `grant_id` sequence is 0,1,2,3,0,1,2,3, and each `ack` count is 2.
- `rst` asserted during WAIT_LO → next cycle state=IDLE and all outputs at reset values. After the in-flight frame ends, pending `req[3]` is granted with `ptr`=0 ordering.
- With `UART_ARB_TIMEOUT_EN` and `tx_busy` tied 0 after an issue → `err` rises at cycle issue+1+`TIMEOUT`, and the FSM returns to IDLE.
- `req[1]` pulsed for one cycle while in WAIT_LO → no `ack[1]` and no transmit.
